// File: rtl/axis_axi_write_arbiter_pkg.sv
// Shared definitions for the two-source AXI4-Stream to AXI4-Lite write arbiter.
package axis_axi_write_arbiter_pkg;

  // Transaction sequencing: wait for a word, run AW/W, collect B.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Round-robin pick between two requesters. A lone requester always wins;
  // on a tie the source that did not own the last transaction wins.
  function automatic logic rr_select(input logic req0, input logic req1,
                                     input logic last_grant);
    return (req0 && req1) ? ~last_grant : req1;
  endfunction

endpackage

// File: rtl/axis_axi_write_arbiter.sv
// Two AXI4-Stream sources share one AXI4-Lite write master. Each accepted
// word becomes a single-beat write to the source's fixed address; only one
// transaction is in flight at a time.
module axis_axi_write_arbiter
  import axis_axi_write_arbiter_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned ADDR0          = 0,
  parameter int unsigned ADDR1          = 4
) (
  input  logic                          aclk,
  input  logic                          areset,

  input  logic [AXI_DATA_WIDTH-1:0]     s0_axis_tdata,
  input  logic                          s0_axis_tvalid,
  output logic                          s0_axis_tready,
  input  logic [AXI_DATA_WIDTH-1:0]     s1_axis_tdata,
  input  logic                          s1_axis_tvalid,
  output logic                          s1_axis_tready,

  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic                          busy,
  output logic                          grant,
  output logic [1:0]                    err
);

  state_t state;
  logic   sel;
  logic   any_req;
  logic   aw_done;
  logic   w_done;

  // Requester selection and channel-completion terms used by the FSM.
  // NOTE: every signal driven here gets a value on every path, so no latch can form.
  always_comb begin
    any_req = s0_axis_tvalid | s1_axis_tvalid;
    sel     = rr_select(s0_axis_tvalid, s1_axis_tvalid, grant);
    // A channel counts as done if it already finished or finishes this cycle.
    aw_done = ~m_axi_awvalid | m_axi_awready;
    w_done  = ~m_axi_wvalid  | m_axi_wready;
  end

  // Only the selected source sees tready, and only while idle.
  assign s0_axis_tready = (state == ST_IDLE) & s0_axis_tvalid & ~sel;
  assign s1_axis_tready = (state == ST_IDLE) & s1_axis_tvalid &  sel;

  assign m_axi_wstrb = '1;
  assign busy        = (state != ST_IDLE);

  // Transaction FSM with registered AXI outputs and sticky error flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      grant         <= 1'b1;   // source 0 wins the first tie
      err           <= 2'b00;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            m_axi_wdata   <= sel ? s1_axis_tdata : s0_axis_tdata;
            m_axi_awaddr  <= sel ? AXI_ADDR_WIDTH'(ADDR1) : AXI_ADDR_WIDTH'(ADDR0);
            grant         <= sel;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          // AW and W retire independently; a low valid is unaffected.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            state        <= ST_IDLE;
            if (m_axi_bresp != RESP_OKAY) err[grant] <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_axi_write_arbiter.md
Name: axis_axi_write_arbiter

Overview:
- Two-requester round-robin arbiter that turns words from two AXI4-Stream sources into single-beat AXI4-Lite write transactions on one shared master port.
- Sits upstream of AXI4-Lite write-only slaves such as the stream-output writer cores, so two producers can share one configuration or data register path.
- Each source has a fixed target address.
- Exactly one transaction is outstanding at a time; a new grant is issued only after the write response completes.

Parameters:
- AXI_DATA_WIDTH, 32, data width of the stream sources and the AXI4-Lite W channel.
- AXI_ADDR_WIDTH, 16, AXI4-Lite address width.
- ADDR0, 0, AXI4-Lite write address used for words from source 0.
- ADDR1, 4, AXI4-Lite write address used for words from source 1.

Ports:
- aclk  in  1  system clock; all logic rising-edge.
- areset  in  1  reset, asynchronous, active-high.
- s0_axis_tdata  in  AXI_DATA_WIDTH  source 0 data.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata  in  AXI_DATA_WIDTH  source 1 data.
- s1_axis_tvalid  in  1  source 1 valid.
- s1_axis_tready  out  1  source 1 ready.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  AXI_DATA_WIDTH  write data.
- m_axi_wstrb  out  AXI_DATA_WIDTH/8  constant all ones.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response code.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- busy  out  1  high while a transaction is in flight (state not IDLE).
- grant  out  1  index of the source owning the current or last transaction.
- err  out  2  sticky per-source flag; bit i is set when a response for source i has bresp != 0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; awvalid, wvalid, bready, busy = 0.
  - grant=1, so source 0 wins the first tie.
  - err=0; awaddr=0; wdata=0; tready outputs=0.
- States: IDLE, REQ, RESP.
- IDLE:
  - Requester selection: if exactly one tvalid is high, select it. If both are high, select ~grant (round-robin).
  - tready: combinationally high for the selected source only, in the same cycle. Both treadys are 0 when no tvalid is high.
  - On the handshake: capture tdata into wdata and ADDRi into awaddr; set grant=i, awvalid=1, wvalid=1; go to REQ.
  - Latency: one cycle from stream handshake to awvalid/wvalid high.
- REQ:
  - awvalid drops on the cycle after awready&awvalid; wvalid drops on the cycle after wready&wvalid.
  - AW and W complete independently, in either order or in the same cycle.
  - awaddr and wdata stay stable while their valid is high.
  - When both channels are done (including completion in the current cycle): bready=1; go to RESP next cycle.
  - Both treadys are 0 in REQ and RESP.
- RESP:
  - bready=1 until bvalid is seen. On bvalid&bready: bready=0, go to IDLE.
  - If bresp != 0, set err[grant].
  - IDLE may grant again on the cycle after returning, giving at least 3 cycles per transaction.
- AXI rule: valids are never deasserted before their handshake, and never depend combinationally on ready.
- Stalls: no timeout. A slave that never responds holds the block in REQ or RESP, busy=1 indefinitely.
- Fairness:
  - Under continuous requests from both sources, grants alternate 0,1,0,1.
  - A lone requester is served back to back.
- Reset mid-transaction: all valids drop immediately (async) and err clears. The in-flight word is lost; the source already saw its handshake.
- err bits clear only on reset.

Decomposition:
- Shared package: state encoding constants (IDLE/REQ/RESP) and the OKAY response constant 2'b00.
- No sub-module is needed; round-robin selection is a few lines inline.
- Optional sub-module for N>2 generalisation later: rr_arbiter (request vector in, one-hot grant out, last-grant pointer).

Test Plan:
- Reset, then s0 sends 0xDEADBEEF with a slave that is always ready and responds OKAY next cycle -> one write awaddr=0x0000, wdata=0xDEADBEEF, wstrb=0xF; busy 1 for 3 cycles; err=0.
- Both sources valid continuously (s0=0x11, s1=0x22) for 4 words each -> AW addresses in order 0,4,0,4,0,4,0,4; data order matches; never two treadys high together.
- Slave holds wready low 5 cycles while awready is immediate -> awvalid drops after 1 cycle; wvalid is held 6 cycles with stable wdata; bready rises only after the W handshake.
- Slave returns bresp=2'b10 for an s1 write -> err=2'b10 sticky through subsequent OKAY writes; cleared only by areset.
- areset pulsed during REQ (awvalid=1) -> awvalid, wvalid, bready and busy go to 0 asynchronously; after release, the first grant goes to s0 when both are valid.
- Only s1 valid for 3 words back to back -> three writes to address 4, each starting the cycle after the previous B handshake.
